// File: rtl/mvp_matrix_sequencer.sv
// mvp_matrix_sequencer
//
// Drives a shared 4x4 matrix-matrix multiplier to build model-view-projection
// matrices. A camera update computes PV = P*V once and caches it. Each model
// matrix M_k that follows is then multiplied as MVP_k = PV*M_k and presented
// downstream with a wrapping sequence id.
//
// Ports
//   clk, rst              : single clock, synchronous active-high reset
//   cam_P, cam_V          : projection / view matrices
//   cam_dv / cam_ready    : camera update handshake (camera beats model)
//   model_M               : model matrix
//   model_dv / model_ready: model handshake
//   mvp, mvp_id, mvp_dv   : registered result, its id, valid (held until taken)
//   mvp_ready             : downstream accept
//   pv_valid              : a PV matrix is cached
//   mul_A, mul_B, mul_i_dv: multiplier operands (product A*B) and start pulse
//   mul_C, mul_o_dv       : multiplier result and result strobe
//   mul_o_ready           : multiplier idle, a start may be issued
//
// Matrices are packed [row][col][element]. No arithmetic is done here, so
// elements pass through at full width.

module mvp_matrix_sequencer #(
  parameter int DATAWIDTH = 18,
  parameter int IDW       = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] cam_P,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] cam_V,
  input  logic                                cam_dv,
  output logic                                cam_ready,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] model_M,
  input  logic                                model_dv,
  output logic                                model_ready,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] mvp,
  output logic [IDW-1:0]                      mvp_id,
  output logic                                mvp_dv,
  input  logic                                mvp_ready,
  output logic                                pv_valid,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] mul_A,
  output logic signed [3:0][3:0][DATAWIDTH-1:0] mul_B,
  output logic                                mul_i_dv,
  input  logic signed [3:0][3:0][DATAWIDTH-1:0] mul_C,
  input  logic                                mul_o_dv,
  input  logic                                mul_o_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PV_ISSUE,
    S_PV_WAIT,
    S_READY,
    S_M_ISSUE,
    S_M_WAIT,
    S_OUT
  } state_t;

  state_t state;
  state_t state_n;

  logic signed [3:0][3:0][DATAWIDTH-1:0] pv;
  logic [IDW-1:0]                        id_cnt;

  logic cam_take;
  logic model_take;
  logic in_issue;

  // Handshake readies depend only on state and cam_dv; model_ready is
  // withheld whenever the camera is asking, which gives the camera priority.
  assign cam_ready   = (state == S_IDLE) || (state == S_READY);
  assign model_ready = (state == S_READY) && !cam_dv;
  assign cam_take    = cam_dv && cam_ready;
  assign model_take  = model_dv && model_ready;
  assign in_issue    = (state == S_PV_ISSUE) || (state == S_M_ISSUE);

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:     if (cam_take) state_n = S_PV_ISSUE;
      S_PV_ISSUE: if (mul_i_dv) state_n = S_PV_WAIT;
      S_PV_WAIT:  if (mul_o_dv) state_n = S_READY;
      S_READY: begin
        if (cam_take)        state_n = S_PV_ISSUE;
        else if (model_take) state_n = S_M_ISSUE;
      end
      S_M_ISSUE:  if (mul_i_dv) state_n = S_M_WAIT;
      S_M_WAIT:   if (mul_o_dv) state_n = S_OUT;
      S_OUT:      if (mvp_ready) state_n = S_READY;
      default:    state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      mvp_dv   <= 1'b0;
      mvp      <= '0;
      mvp_id   <= '0;
      pv_valid <= 1'b0;
      mul_i_dv <= 1'b0;
      mul_A    <= '0;
      mul_B    <= '0;
      id_cnt   <= '0;
    end else begin
      state <= state_n;

      // The operand registers double as the latched P/V or PV/M pair; they
      // load on the accepting edge and hold until the next accept.
      if (cam_take) begin
        mul_A <= cam_P;
        mul_B <= cam_V;
      end else if (model_take) begin
        mul_A <= pv;
        mul_B <= model_M;
      end

      // Start pulse is registered. The multiplier is owned exclusively, so
      // if it is ready on the accepting edge it is still ready in the first
      // ISSUE cycle. Otherwise keep trying each ISSUE cycle until it is.
      mul_i_dv <= 1'b0;
      if (cam_take || model_take)
        mul_i_dv <= mul_o_ready;
      else if (in_issue && !mul_i_dv)
        mul_i_dv <= mul_o_ready;

      if ((state == S_PV_WAIT) && mul_o_dv) begin
        pv_valid <= 1'b1;
        id_cnt   <= '0;
      end

      if ((state == S_M_WAIT) && mul_o_dv) begin
        mvp    <= mul_C;
        mvp_id <= id_cnt;
        mvp_dv <= 1'b1;
      end

      if ((state == S_OUT) && mvp_ready) begin
        mvp_dv <= 1'b0;
        id_cnt <= id_cnt + 1'b1;
      end
    end
  end

  // Cached PV is data only. The old value stays until a new product
  // replaces it; a strobe arriving while reset is held is discarded.
  always_ff @(posedge clk) begin
    if (!rst && (state == S_PV_WAIT) && mul_o_dv)
      pv <= mul_C;
  end

endmodule

// File: tb/tb_mvp_matrix_sequencer.sv
module tb_mvp_matrix_sequencer;

  localparam int DW  = 18;
  localparam int IDW = 2;
  localparam int LAT = 4;

  typedef logic [3:0][3:0][DW-1:0] mat_t;

  typedef struct {
    mat_t       m;
    mat_t       exp;
    logic [1:0] id;
  } vec_t;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  mat_t           cam_P = '0, cam_V = '0, model_M = '0;
  logic           cam_dv = 1'b0, model_dv = 1'b0, mvp_ready = 1'b1;
  logic           cam_ready, model_ready, mvp_dv, pv_valid, mul_i_dv;
  mat_t           mvp, mul_A, mul_B, mul_C;
  logic [IDW-1:0] mvp_id;
  logic           mul_o_dv, mul_o_ready;

  // multiplier stand-in
  logic stall = 1'b0;
  logic keep_mul = 1'b0;
  logic busy = 1'b0;
  int   cnt = 0;
  mat_t acc_C = '0;
  mat_t mdl_C = '0;
  logic mdl_odv = 1'b0;

  int   idv_cnt = 0;
  int   odv_cnt = 0;
  logic last_odv = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  mvp_matrix_sequencer #(.DATAWIDTH(DW), .IDW(IDW)) dut (
    .clk(clk), .rst(rst),
    .cam_P(cam_P), .cam_V(cam_V), .cam_dv(cam_dv), .cam_ready(cam_ready),
    .model_M(model_M), .model_dv(model_dv), .model_ready(model_ready),
    .mvp(mvp), .mvp_id(mvp_id), .mvp_dv(mvp_dv), .mvp_ready(mvp_ready),
    .pv_valid(pv_valid),
    .mul_A(mul_A), .mul_B(mul_B), .mul_i_dv(mul_i_dv),
    .mul_C(mul_C), .mul_o_dv(mul_o_dv), .mul_o_ready(mul_o_ready)
  );

  function automatic mat_t matmul(mat_t a, mat_t b);
    mat_t   c;
    longint s, x, y;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        s = 0;
        for (int k = 0; k < 4; k++) begin
          x = longint'($signed(a[i][k]));
          y = longint'($signed(b[k][j]));
          s = s + x * y;
        end
        c[i][j] = s[DW-1:0];
      end
    return c;
  endfunction

  assign mul_C       = mdl_C;
  assign mul_o_dv    = mdl_odv;
  assign mul_o_ready = !busy && !stall;

  always @(posedge clk) begin
    if (rst && !keep_mul) begin
      busy    <= 1'b0;
      mdl_odv <= 1'b0;
      cnt     <= 0;
    end else begin
      mdl_odv <= 1'b0;
      if (mul_i_dv && mul_o_ready) begin
        busy  <= 1'b1;
        cnt   <= LAT - 1;
        acc_C <= matmul(mul_A, mul_B);
      end else if (busy) begin
        if (cnt == 0) begin
          busy    <= 1'b0;
          mdl_odv <= 1'b1;
          mdl_C   <= acc_C;
        end else begin
          cnt <= cnt - 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    if (mul_i_dv === 1'b1) idv_cnt++;
    if (mul_o_dv === 1'b1) odv_cnt++;
    last_odv <= mul_o_dv;
  end

  function automatic mat_t ident(int sc);
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = DW'(sc);
    return m;
  endfunction

  function automatic mat_t diagm();
    mat_t m = '0;
    for (int i = 0; i < 4; i++) m[i][i] = DW'(i + 1);
    return m;
  endfunction

  function automatic mat_t seqm(int base);
    mat_t m;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) m[i][j] = DW'(base + i * 4 + j);
    return m;
  endfunction

  function automatic mat_t scale(mat_t m, int s);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[i][j] = DW'(int'(m[i][j]) * s);
    return r;
  endfunction

  // diag(1,2,3,4) * M scales row i by i+1
  function automatic mat_t diag_rows(mat_t m);
    mat_t r;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) r[i][j] = DW'(int'(m[i][j]) * (i + 1));
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic chkm(string nm, mat_t act, mat_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic send_cam(mat_t p, mat_t v);
    int n = 0;
    while (!cam_ready && n < 100) begin tick(); n++; end
    chk("cam_ready_wait", cam_ready, 1);
    cam_P  = p;
    cam_V  = v;
    cam_dv = 1'b1;
    tick();
    cam_dv = 1'b0;
  endtask

  task automatic send_model(mat_t m);
    int   n = 0;
    logic acc = 1'b0;
    model_M  = m;
    model_dv = 1'b1;
    while (!acc && n < 200) begin
      acc = model_ready;
      tick();
      n++;
    end
    model_dv = 1'b0;
    chk("model_accept", acc, 1);
  endtask

  task automatic wait_mvp(string nm);
    int n = 0;
    while (!mvp_dv && n < 100) begin tick(); n++; end
    chk(nm, mvp_dv, 1);
  endtask

  vec_t       tbl[6];
  logic [1:0] ids[6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
  int         base;
  int         n;
  logic       ok;
  mat_t       exp_m;

  initial begin
    for (int k = 0; k < 6; k++) begin
      tbl[k].m   = seqm(k * 16);
      tbl[k].exp = diag_rows(seqm(k * 16));
      tbl[k].id  = ids[k];
    end

    // reset and idle
    rst = 1'b1;
    tick();
    tick();
    chk("rst_cam_ready", cam_ready, 1);
    chk("rst_model_ready", model_ready, 0);
    chk("rst_mvp_dv", mvp_dv, 0);
    chkm("rst_mvp", mvp, '0);
    chk("rst_mvp_id", mvp_id, 0);
    chk("rst_pv_valid", pv_valid, 0);
    chk("rst_mul_i_dv", mul_i_dv, 0);
    chkm("rst_mul_A", mul_A, '0);
    chkm("rst_mul_B", mul_B, '0);
    rst      = 1'b0;
    model_M  = seqm(5);
    model_dv = 1'b1;
    #1;
    chk("idle_model_ready", model_ready, 0);
    tick();
    model_dv = 1'b0;
    repeat (3) tick();
    chk("idle_no_issue", idv_cnt, 0);
    chk("idle_pv_valid", pv_valid, 0);
    chk("idle_mvp_dv", mvp_dv, 0);

    // identity camera, issue stalled three cycles by the multiplier
    stall = 1'b1;
    send_cam(ident(1), ident(1));
    chk("pv_issue_cam_ready", cam_ready, 0);
    repeat (3) tick();
    chk("stall_no_issue", idv_cnt, 0);
    stall = 1'b0;
    n = 0;
    while (!pv_valid && n < 100) begin tick(); n++; end
    chk("pv_valid_rise", pv_valid, 1);
    chk("pv_after_odv", last_odv, 1);
    chk("pv_one_issue", idv_cnt, 1);
    send_model(seqm(0));
    wait_mvp("id_mvp_dv");
    chkm("id_mvp", mvp, seqm(0));
    chk("id_mvp_id", mvp_id, 0);
    chk("id_two_issues", idv_cnt, 2);
    tick();
    chk("id_mvp_dv_drop", mvp_dv, 0);

    // camera and model together in READY: camera wins
    base     = idv_cnt;
    cam_P    = ident(2);
    cam_V    = ident(1);
    cam_dv   = 1'b1;
    model_M  = seqm(40);
    model_dv = 1'b1;
    #1;
    chk("sim_model_ready", model_ready, 0);
    chk("sim_cam_ready", cam_ready, 1);
    tick();
    cam_dv = 1'b0;
    chk("sim_taken_model_ready", model_ready, 0);
    send_model(seqm(40));
    wait_mvp("sim_mvp_dv");
    chkm("sim_mvp", mvp, scale(seqm(40), 2));
    chk("sim_mvp_id", mvp_id, 0);
    chk("sim_issues", idv_cnt - base, 2);
    tick();

    // stream with id wrap, PV = diag(1,2,3,4)
    send_cam(diagm(), ident(1));
    for (int k = 0; k < 6; k++) begin
      send_model(tbl[k].m);
      wait_mvp($sformatf("stream%0d_dv", k));
      chkm($sformatf("stream%0d_mvp", k), mvp, tbl[k].exp);
      chk($sformatf("stream%0d_id", k), mvp_id, tbl[k].id);
      tick();
    end

    // backpressure for 10 cycles with a model waiting
    mvp_ready = 1'b0;
    exp_m     = diag_rows(seqm(200));
    send_model(seqm(200));
    wait_mvp("bp_mvp_dv");
    chkm("bp_mvp", mvp, exp_m);
    chk("bp_mvp_id", mvp_id, 2);
    base     = idv_cnt;
    model_M  = seqm(7);
    model_dv = 1'b1;
    ok       = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      if (mvp_dv !== 1'b1 || mvp !== exp_m || mvp_id !== 2'd2 || model_ready !== 1'b0)
        ok = 1'b0;
    end
    chk("bp_stable", ok, 1);
    chk("bp_no_issue", idv_cnt - base, 0);
    model_dv  = 1'b0;
    mvp_ready = 1'b1;
    tick();
    chk("bp_release", mvp_dv, 0);

    // reset while in M_WAIT; the multiplier keeps running and strobes late
    keep_mul = 1'b1;
    send_model(seqm(300));
    tick();
    tick();
    base = odv_cnt;
    rst  = 1'b1;
    tick();
    rst  = 1'b0;
    ok   = 1'b1;
    for (int c = 0; c < 8; c++) begin
      tick();
      if (mvp_dv !== 1'b0 || pv_valid !== 1'b0 || cam_ready !== 1'b1 ||
          model_ready !== 1'b0 || mvp !== '0)
        ok = 1'b0;
    end
    chk("mrst_late_odv_seen", odv_cnt > base, 1);
    chk("mrst_idle", ok, 1);
    chk("mrst_mvp_id", mvp_id, 0);
    keep_mul = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
